approx_mul_ha_pipe: RTL
=======================

Name: approx_mul_ha_pipe

Overview:
- Parametrised, pipelined unsigned WIDTH x WIDTH approximate multiplier built on the half-adder-array partial-product scheme.
- Partial-product rows are paired into WIDTH/2 half-adder arrays. Per-transaction mode selects exact, OR-sum or truncated compression in the low columns.
- The arrays are summed to the product. An on-line error monitor compares against the exact product.
- Sits between operand-producing datapath stages and the characterisation harness, with a valid/ready stream on both sides.

Parameters:
- WIDTH, 8, operand width; even, >= 4.
- APPROX_COLS, 6, global column index below which approximation applies; 0..2*WIDTH.
- CNT_W, 32, width of the transaction counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat.
- x  in  WIDTH  multiplicand.
- y  in  WIDTH  multiplier.
- mode  in  2  0 exact, 1 OR-sum approximate, 2 truncate, 3 treated as exact.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts product.
- prod  out  2*WIDTH  approximate product.
- err  out  2*WIDTH  exact product minus prod; always >= 0.
- stats_clr  in  1  synchronous clear of statistics.
- err_max  out  2*WIDTH  maximum err over counted transactions.
- tx_cnt  out  CNT_W  number of counted transactions; saturating.

Behaviour:
- One clock (clk); reset synchronous, active-high (rst).
- Reset values:
  - all stage valids = 0, so out_valid = 0;
  - prod = 0, err = 0;
  - err_max = 0, tx_cnt = 0.
- Pipeline of 3 register stages; latency 3 cycles from accepted input to out_valid with no stall.
  - S1 registers x, y and mode.
  - S2 registers the WIDTH/2 half-adder arrays.
  - S3 registers prod and err.
- Handshake:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall.
  - When stall is high, all stages hold. Otherwise every stage advances and bubbles propagate (they are not collapsed).
  - Input is accepted on in_valid & in_ready.
  - Output is transferred on out_valid & out_ready.
  - prod and err are stable while out_valid & ~out_ready.
- Array k (k = 0..WIDTH/2-1) combines two rows:
  - row a[j] = y[j] & x[2k];
  - row b[j] = y[j] & x[2k+1], at weight j+1;
  - global column of local column j is c = 2k + j.
- Local columns:
  - Column 0 holds a[0] alone and goes to t[0].
  - Columns 1..WIDTH-1 overlap a[j] and b[j-1]. A half adder gives sum t[j] and carry bt[j-1] (weight j+1).
  - Column WIDTH: carry of column WIDTH-1 goes to t[WIDTH]; b[WIDTH-1] goes to bt[WIDTH-2].
  - Array value = sum t[j]*2^j + sum bt[i]*2^(i+2).
- Mode rules, for column c < APPROX_COLS:
  - mode 1: half adder replaced by t[j] = a|b and carry = 0; single-bit columns unchanged.
  - mode 2: the t bit and the bt bit at that column are forced 0, and carries generated there are dropped.
  - mode 0/3: exact.
- prod = sum over k of array_k << 2k, computed mod 2^(2*WIDTH); it cannot overflow.
- err = x*y - prod, using the exact product of the S1 operands carried through S2.
- Statistics, updated on each output transfer:
  - err_max = max(err_max, err).
  - tx_cnt increments, saturating at all ones.
  - stats_clr zeroes both and has priority: a transfer in the same cycle is not counted.
- rst mid-operation discards all in-flight beats and statistics.

Test Plan (WIDTH=8, APPROX_COLS=6):
- x=3, y=3, mode 0 -> prod=9, err=0; mode 1 -> prod=7, err=2; mode 2 -> prod=0, err=9. out_valid exactly 3 cycles after acceptance.
- x=0x30, y=0x01: mode 1 -> prod=48, err=0; mode 2 -> prod=0, err=48. Exercises array 2 only.
- x=255, y=255, mode 0 and mode 3 -> prod=65025, err=0. Random mode-0 sweep over 1000 operand pairs -> err always 0.
- Back-to-back stream of 5 beats with out_ready low for cycles 4-7:
  - in_ready low whenever out_valid & ~out_ready;
  - no beat lost or duplicated; outputs in order; prod/err held during the stall.
- Statistics:
  - After transfers with err = 2, 48, 9 -> err_max=48, tx_cnt=3.
  - stats_clr asserted in the same cycle as a 4th transfer (err 100) -> err_max=0, tx_cnt=0.
  - CNT_W=2 build -> tx_cnt saturates at 3.
- rst asserted with 2 beats in flight -> out_valid=0 on the next cycle, prod=0, err=0, err_max=0, tx_cnt=0; a new beat after reset completes in 3 cycles.

Source files
------------

// File: rtl/approx_mul_ha_pipe.sv
`default_nettype none
// ============================================================================
// Module      : approx_mul_ha_pipe
// Description : Three-stage pipelined unsigned WIDTH x WIDTH approximate
//               multiplier. Pairs of partial-product rows are compressed by
//               half-adder arrays whose low columns are exact, OR-summed or
//               truncated per transaction. An on-line monitor reports the
//               error against the exact product and keeps running statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module approx_mul_ha_pipe #(
    parameter int WIDTH       = 8,
    parameter int APPROX_COLS = 6,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    input  logic [1:0]           mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   prod,
    output logic [2*WIDTH-1:0]   err,
    input  logic                 stats_clr,
    output logic [2*WIDTH-1:0]   err_max,
    output logic [CNT_W-1:0]     tx_cnt
);

    localparam int PW   = 2 * WIDTH;   // product width
    localparam int NARR = WIDTH / 2;   // number of half-adder arrays
    localparam int TW   = WIDTH + 1;   // sum-bit vector width per array
    localparam int BW   = WIDTH - 1;   // carry-bit vector width per array

    localparam logic [1:0] MODE_OR = 2'd1;
    localparam logic [1:0] MODE_TR = 2'd2;

    // ------------------------------------------------------------------
    // Handshake: a waiting, unaccepted output freezes the whole pipe.
    // ------------------------------------------------------------------
    logic stall_w;
    logic v1_q, v2_q, v3_q;

    assign stall_w   = v3_q & ~out_ready;
    assign in_ready  = ~stall_w;
    assign out_valid = v3_q;

    // ------------------------------------------------------------------
    // Stage 1: operand capture
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] x_q, y_q;
    logic [1:0]       mode_q;

    // Capture operands and mode; bubbles advance as invalid beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q   <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
            mode_q <= '0;
        end else if (!stall_w) begin
            v1_q   <= in_valid;
            x_q    <= x;
            y_q    <= y;
            mode_q <= mode;
        end
    end

    // ------------------------------------------------------------------
    // Half-adder arrays (combinational from stage 1)
    // ------------------------------------------------------------------
    logic            is_or_w, is_tr_w;
    logic [NARR*TW-1:0] t_d, t_q;
    logic [NARR*BW-1:0] bt_d, bt_q;
    logic [PW-1:0]      exact_d, exact_q;

    assign is_or_w = (mode_q == MODE_OR);
    assign is_tr_w = (mode_q == MODE_TR);
    assign exact_d = PW'(x_q) * PW'(y_q);

    for (genvar k = 0; k < NARR; k++) begin : g_array
        logic [WIDTH-1:0] row_a, row_b;
        logic [TW-1:0]    t_w;
        logic [BW-1:0]    bt_w;
        logic             hs_w, hc_w;

        assign row_a = y_q & {WIDTH{x_q[2*k]}};
        assign row_b = y_q & {WIDTH{x_q[2*k+1]}};

        // Compress rows a and b (b one place up) column by column. In the
        // truncated region every bit produced in a column is dropped,
        // including the carry it would send upward.
        always_comb begin
            t_w  = '0;
            bt_w = '0;
            hs_w = 1'b0;
            hc_w = 1'b0;
            t_w[0] = row_a[0] & ~(is_tr_w && ((2*k) < APPROX_COLS));
            for (int j = 1; j < WIDTH; j++) begin
                if (((2*k + j) < APPROX_COLS) && is_or_w) begin
                    hs_w = row_a[j] | row_b[j-1];
                    hc_w = 1'b0;
                end else if (((2*k + j) < APPROX_COLS) && is_tr_w) begin
                    hs_w = 1'b0;
                    hc_w = 1'b0;
                end else begin
                    hs_w = row_a[j] ^ row_b[j-1];
                    hc_w = row_a[j] & row_b[j-1];
                end
                t_w[j] = hs_w;
                if (j == WIDTH - 1) begin
                    t_w[WIDTH] = hc_w;
                end else begin
                    bt_w[j-1] = hc_w;
                end
            end
            // Top row bit passes straight through the last column.
            bt_w[BW-1] = row_b[WIDTH-1] & ~(is_tr_w && ((2*k + WIDTH) < APPROX_COLS));
        end

        assign t_d[k*TW +: TW]  = t_w;
        assign bt_d[k*BW +: BW] = bt_w;
    end

    // ------------------------------------------------------------------
    // Stage 2: array outputs plus the exact product for the monitor
    // ------------------------------------------------------------------
    // Register array bits and the exact reference product together.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q    <= 1'b0;
            t_q     <= '0;
            bt_q    <= '0;
            exact_q <= '0;
        end else if (!stall_w) begin
            v2_q    <= v1_q;
            t_q     <= t_d;
            bt_q    <= bt_d;
            exact_q <= exact_d;
        end
    end

    // ------------------------------------------------------------------
    // Final summation and error
    // ------------------------------------------------------------------
    logic [PW-1:0] prod_d, err_d;

    // Weight each array by its row pair and accumulate; fits in PW bits.
    always_comb begin
        prod_d = '0;
        for (int k = 0; k < NARR; k++) begin
            prod_d = prod_d + ((PW'(t_q[k*TW +: TW]) + (PW'(bt_q[k*BW +: BW]) << 2)) << (2*k));
        end
        err_d = exact_q - prod_d;
    end

    // ------------------------------------------------------------------
    // Stage 3: product and error, held while the consumer stalls
    // ------------------------------------------------------------------
    logic [PW-1:0] prod_q, err_q;

    // Output register; holding on stall keeps prod/err stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            v3_q   <= 1'b0;
            prod_q <= '0;
            err_q  <= '0;
        end else if (!stall_w) begin
            v3_q   <= v2_q;
            prod_q <= prod_d;
            err_q  <= err_d;
        end
    end

    assign prod = prod_q;
    assign err  = err_q;

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
    logic [PW-1:0]    err_max_q;
    logic [CNT_W-1:0] tx_cnt_q;

    // Track max error and saturating transfer count; clear wins over a
    // simultaneous transfer.
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            err_max_q <= '0;
            tx_cnt_q  <= '0;
        end else if (v3_q && out_ready) begin
            if (err_q > err_max_q) begin
                err_max_q <= err_q;
            end
            if (tx_cnt_q != {CNT_W{1'b1}}) begin
                tx_cnt_q <= tx_cnt_q + 1'b1;
            end
        end
    end

    assign err_max = err_max_q;
    assign tx_cnt  = tx_cnt_q;

endmodule
`default_nettype wire
